piton_dcr_launch_ctrl: RTL
==========================

PITON_DCR_LAUNCH_CTRL -- requirements
Module: piton_dcr_launch_ctrl

Interface
REQ-001 Parameters SHALL be: VX_DCR_ADDR_WIDTH, 8, DCR address width; VX_DCR_DATA_WIDTH, 32, DCR data width; DCR_STARTUP_ADDR0, 8'h01, startup PC low; DCR_STARTUP_ADDR1, 8'h02, startup PC high; DCR_STARTUP_ARG0, 8'h03, kernel argument pointer; STALL_LIMIT, 1024, buffer_full cycles before stall error.
REQ-002 Clocking: one clock; reset is asynchronous and active-high. Ports: clk in 1, sole clock; rst in 1, asynchronous active-high reset.
REQ-003 host_wr_valid in 1: direct DCR write request. host_wr_addr in ADDR_W: its address. host_wr_data in DATA_W: its data. host_wr_ready out 1: write accepted this cycle.
REQ-004 launch_req in 1: level launch request. launch_pc in 32: startup PC. launch_arg in 32: argument pointer. launch_ack out 1: one-cycle pulse, request latched. launch_done out 1: one-cycle pulse, last sequence write issued.
REQ-005 buffer_wr_valid out 1, buffer_wr_addr out ADDR_W, buffer_wr_data out DATA_W: write into DCR buffer. buffer_full in 1: buffer cannot take a write.
REQ-006 busy out 1: FSM not IDLE. stall_err out 1: sticky stall flag. dcr_wr_count out 16: total writes issued.

Function
REQ-007 FSM states SHALL be IDLE, SEQ_PC0, SEQ_PC1, SEQ_ARG, DONE.
REQ-008 Buffer has no ready; a write SHALL occur exactly in cycles where buffer_wr_valid=1. buffer_wr_valid SHALL never be 1 while buffer_full=1, combinationally.
REQ-009 IDLE: host_wr_ready = host_wr_valid & ~buffer_full; accepted host write drives buffer_wr_valid=1, addr/data = host_wr_addr/host_wr_data, same cycle (zero latency).
REQ-010 IDLE with launch_req=1: latch launch_pc/launch_arg, pulse launch_ack, go SEQ_PC0 next cycle.
REQ-011 Host write and launch_req together in IDLE: both SHALL be accepted that cycle; host write issues first, sequence starts next cycle.
REQ-012 SEQ_PC0 issues (DCR_STARTUP_ADDR0, pc); SEQ_PC1 issues (DCR_STARTUP_ADDR1, 32'h0); SEQ_ARG issues (DCR_STARTUP_ARG0, arg). Each state advances only in the cycle its write issues; held while buffer_full=1.
REQ-013 SEQ_ARG issue cycle SHALL pulse launch_done and go DONE; DONE returns to IDLE unconditionally next cycle, no write.
REQ-014 host_wr_ready SHALL be 0 in every state except IDLE; launch_req outside IDLE SHALL be ignored (no ack); requester holds launch_req until launch_ack.
REQ-015 Minimum launch: ack cycle N, writes N+1..N+3, launch_done N+3, IDLE at N+5.
REQ-016 dcr_wr_count SHALL increment by 1 per issued write, wrapping 16'hFFFF -> 0.
REQ-017 Stall counter SHALL increment each cycle buffer_full=1 while a write is pending (IDLE with host_wr_valid, or any SEQ state), clear otherwise; reaching STALL_LIMIT sets stall_err, cleared only by rst. Counter saturates.
REQ-018 Latched pc/arg SHALL not change during a sequence regardless of launch_* inputs.

Reset
REQ-019 rst=1 SHALL immediately force IDLE, clear latched pc/arg, dcr_wr_count=0, stall counter=0, stall_err=0.
REQ-020 During rst: buffer_wr_valid, host_wr_ready, launch_ack, launch_done, busy = 0; buffer_wr_addr/data = 0.
REQ-021 rst mid-sequence SHALL abandon the sequence; no resumption, no launch_done; requester re-requests.

Verification
REQ-022 Host write addr 8'h05 data 32'hDEADBEEF, buffer_full=0 -> host_wr_ready and buffer_wr_valid same cycle, count 0->1.
REQ-023 Launch pc 32'h8000_0000 arg 32'h0000_1000, buffer_full=0 -> writes (01,80000000),(02,0),(03,1000) on three consecutive cycles, launch_done on third, count=3.
REQ-024 Launch with buffer_full=1 for 5 cycles during SEQ_PC1 -> no valid those cycles, write order unchanged, launch_done delayed by 5.
REQ-025 Host write and launch_req same IDLE cycle -> host write issued first, four total writes in order; host_wr_valid during sequence sees host_wr_ready=0.
REQ-026 STALL_LIMIT=4, buffer_full held with host_wr_valid=1 -> stall_err after 4 cycles, stays 1 after full drops; rst clears.
REQ-027 rst asserted in SEQ_PC1 -> all outputs 0 immediately; after release IDLE, busy=0, no launch_done.

Source files
------------

// File: rtl/piton_dcr_launch_ctrl.sv
// DCR launch sequencer: passes host DCR writes through in IDLE and, on launch, issues PC-low/PC-high/arg writes.
// Zero-latency writes into a ready-less buffer; every issue is held off while buffer_full=1, with a sticky stall flag.
module piton_dcr_launch_ctrl #(
   parameter int VX_DCR_ADDR_WIDTH = 8,
   parameter int VX_DCR_DATA_WIDTH = 32,
   parameter logic [VX_DCR_ADDR_WIDTH-1:0] DCR_STARTUP_ADDR0 = 'h01,
   parameter logic [VX_DCR_ADDR_WIDTH-1:0] DCR_STARTUP_ADDR1 = 'h02,
   parameter logic [VX_DCR_ADDR_WIDTH-1:0] DCR_STARTUP_ARG0  = 'h03,
   parameter int STALL_LIMIT = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         host_wr_valid,
   input  logic [VX_DCR_ADDR_WIDTH-1:0] host_wr_addr,
   input  logic [VX_DCR_DATA_WIDTH-1:0] host_wr_data,
   output logic                         host_wr_ready,
   input  logic                         launch_req,
   input  logic [31:0]                  launch_pc,
   input  logic [31:0]                  launch_arg,
   output logic                         launch_ack,
   output logic                         launch_done,
   output logic                         buffer_wr_valid,
   output logic [VX_DCR_ADDR_WIDTH-1:0] buffer_wr_addr,
   output logic [VX_DCR_DATA_WIDTH-1:0] buffer_wr_data,
   input  logic                         buffer_full,
   output logic                         busy,
   output logic                         stall_err,
   output logic [15:0]                  dcr_wr_count
);

   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT_V = SW'(STALL_LIMIT);

   typedef enum logic [2:0] {IDLE, SEQ_PC0, SEQ_PC1, SEQ_ARG, DONE} state_t;

   state_t          r_state, w_next;
   logic [31:0]     r_pc, r_arg;
   logic [15:0]     r_count;
   logic [SW-1:0]   r_stall_cnt;
   logic            r_stall_err;
   logic            w_pending;

   // Outputs are forced low while rst is high, since reset is asynchronous.
   always_comb begin
      w_next          = r_state;
      host_wr_ready   = 1'b0;
      launch_ack      = 1'b0;
      launch_done     = 1'b0;
      buffer_wr_valid = 1'b0;
      buffer_wr_addr  = '0;
      buffer_wr_data  = '0;
      w_pending       = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_pending       = host_wr_valid;
            host_wr_ready   = host_wr_valid & ~buffer_full & ~rst;
            buffer_wr_valid = host_wr_ready;
            if (host_wr_ready) begin
               buffer_wr_addr = host_wr_addr;
               buffer_wr_data = host_wr_data;
            end
            if (launch_req && !rst) begin
               launch_ack = 1'b1;
               w_next     = SEQ_PC0;
            end
         end
         SEQ_PC0: begin
            w_pending = 1'b1;
            if (!buffer_full && !rst) begin
               buffer_wr_valid = 1'b1;
               buffer_wr_addr  = DCR_STARTUP_ADDR0;
               buffer_wr_data  = VX_DCR_DATA_WIDTH'(r_pc);
               w_next          = SEQ_PC1;
            end
         end
         SEQ_PC1: begin
            w_pending = 1'b1;
            if (!buffer_full && !rst) begin
               buffer_wr_valid = 1'b1;
               buffer_wr_addr  = DCR_STARTUP_ADDR1;
               w_next          = SEQ_ARG;
            end
         end
         SEQ_ARG: begin
            w_pending = 1'b1;
            if (!buffer_full && !rst) begin
               buffer_wr_valid = 1'b1;
               buffer_wr_addr  = DCR_STARTUP_ARG0;
               buffer_wr_data  = VX_DCR_DATA_WIDTH'(r_arg);
               launch_done     = 1'b1;
               w_next          = DONE;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign busy         = (r_state != IDLE) & ~rst;
   assign stall_err    = r_stall_err;
   assign dcr_wr_count = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pc        <= '0;
         r_arg       <= '0;
         r_count     <= '0;
         r_stall_cnt <= '0;
         r_stall_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && launch_req) begin
            r_pc  <= launch_pc;
            r_arg <= launch_arg;
         end
         if (buffer_wr_valid) r_count <= r_count + 16'd1;
         // Saturating stall counter; the flag sets on the edge the count reaches the limit.
         if (w_pending && buffer_full) begin
            if (r_stall_cnt != LIMIT_V) r_stall_cnt <= r_stall_cnt + SW'(1);
            if (r_stall_cnt >= LIMIT_V - SW'(1)) r_stall_err <= 1'b1;
         end else begin
            r_stall_cnt <= '0;
         end
      end
   end

endmodule
